// File: rtl/cci_tx_c0_buffer_pkg.sv
// Shared ASE CCI definitions: TX header width, outstanding-counter width,
// TX channel-0 header bit ranges, and a saturating counter helper.
// No ports; imported by the TX buffer and its storage sub-module.
package cci_tx_c0_buffer_pkg;

  localparam int CCI_TX_HDR_WIDTH      = 61;
  localparam int CCI_OUTSTANDING_CNT_W = 6;

  // TX channel-0 header field ranges
  localparam int TX_HDR_ADDR_LO    = 0;
  localparam int TX_HDR_ADDR_HI    = 31;
  localparam int TX_HDR_MDATA_LO   = 32;
  localparam int TX_HDR_MDATA_HI   = 45;
  localparam int TX_HDR_REQTYPE_LO = 52;
  localparam int TX_HDR_REQTYPE_HI = 55;

  typedef logic [CCI_OUTSTANDING_CNT_W-1:0] outst_cnt_t;

  // Decrement that sticks at zero; a stray response never wraps the counter.
  function automatic outst_cnt_t sat_dec(input outst_cnt_t v);
    return (v == '0) ? '0 : v - outst_cnt_t'(1);
  endfunction

endpackage

// File: rtl/cci_tx_c0_buffer_sync_fifo.sv
// Purpose: single-clock FIFO storage for the TX channel-0 buffer.
// Latency: a push becomes visible at the head one cycle later; no bypass.
// Backpressure: push dropped when full unless a pop occurs the same cycle.
// Ports: clk/resetb, push_i+push_dat_i, pop_i, head_dat_o (0 when empty),
//        full_o, empty_o, count_o (occupancy 0..DEPTH).
module cci_sync_fifo #(
  parameter int WIDTH = 61,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_acc, pop_acc;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);

  // Mask the head so the output reads 0 while empty (including reset).
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/cci_tx_c0_buffer.sv
// Purpose: buffers AFU channel-0 read requests and issues them to the emulator
//          with a cap on issued-but-unreturned reads.
// Latency: 1 cycle push-to-head; issue happens on out_valid & out_ready.
// Backpressure: tx_c0_almostfull at AFULL_THRESH; pushes into a full FIFO
//          without a same-cycle pop are dropped; issue stalls at MAX_OUTSTANDING.
// Ports: clk/resetb; tx_c0_header/tx_c0_rdvalid/tx_c0_almostfull (AFU side);
//        out_header/out_valid/out_ready (emulator side); rx_c0_rdvalid retires
//        one read; outstanding_cnt; overflow_err (sticky).
// Macro ASE_TX_OVERFLOW_CHECK_EN: when defined, overflow_err flags dropped
// pushes and responses arriving with nothing outstanding; otherwise tied to 0.
module cci_tx_c0_buffer
  import cci_tx_c0_buffer_pkg::*;
#(
  parameter int TX_HDR_WIDTH    = CCI_TX_HDR_WIDTH,
  parameter int DEPTH           = 8,
  parameter int AFULL_THRESH    = 6,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic [TX_HDR_WIDTH-1:0]          tx_c0_header,
  input  logic                             tx_c0_rdvalid,
  output logic                             tx_c0_almostfull,
  output logic [TX_HDR_WIDTH-1:0]          out_header,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             rx_c0_rdvalid,
  output logic [CCI_OUTSTANDING_CNT_W-1:0] outstanding_cnt,
  output logic                             overflow_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          issue;
  outst_cnt_t    outst_q, outst_d;

  cci_sync_fifo #(
    .WIDTH (TX_HDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetb     (resetb),
    .push_i     (tx_c0_rdvalid),
    .push_dat_i (tx_c0_header),
    .pop_i      (issue),
    .head_dat_o (out_header),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign out_valid = !fifo_empty && (outst_q < outst_cnt_t'(MAX_OUTSTANDING));
  assign issue     = out_valid && out_ready;

  // Full is the top of the almost-full window, so OR-ing it in changes nothing
  // for any legal threshold and keeps the flag asserted at capacity.
  assign tx_c0_almostfull = fifo_full || (fifo_count >= CW'(AFULL_THRESH));

  always_comb begin
    outst_d = outst_q;
    case ({issue, rx_c0_rdvalid})
      2'b10:   outst_d = outst_q + outst_cnt_t'(1);
      2'b01:   outst_d = sat_dec(outst_q);
      default: outst_d = outst_q;   // issue and return cancel out
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) outst_q <= '0;
    else         outst_q <= outst_d;
  end

  assign outstanding_cnt = outst_q;

`ifdef ASE_TX_OVERFLOW_CHECK_EN
  logic err_q, push_drop, rx_underflow;

  assign push_drop    = tx_c0_rdvalid && fifo_full && !issue;
  assign rx_underflow = rx_c0_rdvalid && (outst_q == '0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) err_q <= 1'b0;
    else         err_q <= err_q || push_drop || rx_underflow;
  end

  assign overflow_err = err_q;
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_cci_tx_c0_buffer.sv
// Purpose: directed self-checking bench for cci_tx_c0_buffer.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there.
// Backpressure: exercises almost-full, drop-on-full and the outstanding cap.
module tb_cci_tx_c0_buffer;

`ifdef ASE_TX_OVERFLOW_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        resetb;

  logic [60:0] a_hdr, a_out_hdr;
  logic        a_push, a_rdy, a_rx, a_af, a_vld, a_err;
  logic [5:0]  a_cnt;

  logic [60:0] b_hdr, b_out_hdr;
  logic        b_push, b_rdy, b_rx, b_af, b_vld, b_err;
  logic [5:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  cci_tx_c0_buffer dut_a (
    .clk              (clk),
    .resetb           (resetb),
    .tx_c0_header     (a_hdr),
    .tx_c0_rdvalid    (a_push),
    .tx_c0_almostfull (a_af),
    .out_header       (a_out_hdr),
    .out_valid        (a_vld),
    .out_ready        (a_rdy),
    .rx_c0_rdvalid    (a_rx),
    .outstanding_cnt  (a_cnt),
    .overflow_err     (a_err)
  );

  cci_tx_c0_buffer #(.MAX_OUTSTANDING(2)) dut_b (
    .clk              (clk),
    .resetb           (resetb),
    .tx_c0_header     (b_hdr),
    .tx_c0_rdvalid    (b_push),
    .tx_c0_almostfull (b_af),
    .out_header       (b_out_hdr),
    .out_valid        (b_vld),
    .out_ready        (b_rdy),
    .rx_c0_rdvalid    (b_rx),
    .outstanding_cnt  (b_cnt),
    .overflow_err     (b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_push = 0; a_rdy = 0; a_rx = 0; a_hdr = '0;
    b_push = 0; b_rdy = 0; b_rx = 0; b_hdr = '0;
  endtask

  // Entered at edge+1; asserts reset mid-cycle, releases it mid-cycle.
  task automatic do_reset();
    idle_inputs();
    #2 resetb = 0;
    step();
    step();
    #2 resetb = 1;
    step();
  endtask

  initial begin
    idle_inputs();
    resetb = 0;
    #3;
    chk("rst_vld", 64'(a_vld), 64'd0);
    chk("rst_af",  64'(a_af),  64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_hdr", 64'(a_out_hdr), 64'd0);
    chk("rst_b_vld", 64'(b_vld), 64'd0);
    step();
    step();
    #2 resetb = 1;
    step();

    // In-order issue of three headers with the emulator always ready
    a_rdy = 1; a_push = 1; a_hdr = 61'h1;
    chk("t1_vld_before", 64'(a_vld), 64'd0);
    step();
    chk("t1_vld_n1", 64'(a_vld), 64'd1);
    chk("t1_hdr1",   64'(a_out_hdr), 64'h1);
    a_hdr = 61'h2;
    step();
    chk("t1_hdr2", 64'(a_out_hdr), 64'h2);
    chk("t1_cnt1", 64'(a_cnt), 64'd1);
    a_hdr = 61'h3;
    step();
    chk("t1_hdr3", 64'(a_out_hdr), 64'h3);
    chk("t1_cnt2", 64'(a_cnt), 64'd2);
    a_push = 0;
    step();
    chk("t1_cnt3",  64'(a_cnt), 64'd3);
    chk("t1_empty", 64'(a_vld), 64'd0);
    // Return all three, then one stray response at zero
    a_rdy = 0; a_rx = 1;
    step(); step(); step();
    chk("t1_cnt_ret", 64'(a_cnt), 64'd0);
    step();
    chk("t1_cnt_sat", 64'(a_cnt), 64'd0);
    chk("t1_err_underflow", 64'(a_err), 64'(EXP_ERR));
    a_rx = 0;
    do_reset();
    chk("t1_err_cleared", 64'(a_err), 64'd0);

    // Fill to full with out_ready low; ninth push is dropped
    for (int i = 0; i < 9; i++) begin
      a_push = 1; a_hdr = 61'(8'h10 + i);
      step();
      if (i == 4) chk("t2_af_at5", 64'(a_af), 64'd0);
      if (i == 5) chk("t2_af_at6", 64'(a_af), 64'd1);
      if (i == 7) chk("t2_err_full", 64'(a_err), 64'd0);
      if (i == 8) chk("t2_err_drop", 64'(a_err), 64'(EXP_ERR));
    end
    a_push = 0; a_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_vld", 64'(a_vld), 64'd1);
      chk("t2_drain_hdr", 64'(a_out_hdr), 64'(8'h10 + i));
      step();
    end
    chk("t2_dropped_absent", 64'(a_vld), 64'd0);
    chk("t2_af_empty", 64'(a_af), 64'd0);
    a_rdy = 0;
    do_reset();

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      a_push = 1; a_hdr = 61'(8'h20 + i);
      step();
    end
    a_hdr = 61'h28; a_rdy = 1;
    chk("t3_head_full", 64'(a_out_hdr), 64'h20);
    step();
    a_push = 0;
    chk("t3_af",       64'(a_af), 64'd1);
    chk("t3_head_next", 64'(a_out_hdr), 64'h21);
    chk("t3_err_none", 64'(a_err), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain_hdr", 64'(a_out_hdr), 64'(8'h20 + i));
      step();
    end
    chk("t3_empty", 64'(a_vld), 64'd0);
    chk("t3_cnt9",  64'(a_cnt), 64'd9);
    a_rdy = 0; a_push = 1; a_hdr = 61'h30;
    step();
    a_push = 0; a_rdy = 1; a_rx = 1;
    step();
    chk("t3_cnt_issue_ret", 64'(a_cnt), 64'd9);
    chk("t3_vld_after",     64'(a_vld), 64'd0);
    a_rdy = 0; a_rx = 0;
    chk("t3_err_end", 64'(a_err), 64'd0);
    do_reset();

    // Outstanding cap of two on the second instance
    for (int i = 0; i < 4; i++) begin
      b_push = 1; b_hdr = 61'(8'h60 + i);
      step();
    end
    b_push = 0; b_rdy = 1;
    chk("t4_vld0", 64'(b_vld), 64'd1);
    chk("t4_hdr0", 64'(b_out_hdr), 64'h60);
    step();
    chk("t4_hdr1", 64'(b_out_hdr), 64'h61);
    chk("t4_cnt1", 64'(b_cnt), 64'd1);
    step();
    chk("t4_cnt2",     64'(b_cnt), 64'd2);
    chk("t4_capped",   64'(b_vld), 64'd0);
    chk("t4_hdr_hold", 64'(b_out_hdr), 64'h62);
    step();
    chk("t4_still_capped", 64'(b_vld), 64'd0);
    chk("t4_cnt_hold",     64'(b_cnt), 64'd2);
    b_rx = 1;
    step();
    b_rx = 0;
    chk("t4_cnt_ret", 64'(b_cnt), 64'd1);
    chk("t4_vld_ret", 64'(b_vld), 64'd1);
    step();
    chk("t4_cnt_third", 64'(b_cnt), 64'd2);
    chk("t4_hdr_third", 64'(b_out_hdr), 64'h63);
    chk("t4_capped2",   64'(b_vld), 64'd0);
    b_rdy = 0;

    // Asynchronous reset mid-operation: 4 queued, 2 outstanding
    for (int i = 0; i < 6; i++) begin
      a_push = 1; a_hdr = 61'(8'h40 + i);
      step();
    end
    a_push = 0; a_rdy = 1;
    step(); step();
    a_rdy = 0;
    chk("t5_cnt_pre", 64'(a_cnt), 64'd2);
    chk("t5_vld_pre", 64'(a_vld), 64'd1);
    #3 resetb = 0;
    #1;
    chk("t5_vld_rst", 64'(a_vld), 64'd0);
    chk("t5_af_rst",  64'(a_af),  64'd0);
    chk("t5_cnt_rst", 64'(a_cnt), 64'd0);
    chk("t5_hdr_rst", 64'(a_out_hdr), 64'd0);
    chk("t5_err_rst", 64'(a_err), 64'd0);
    a_push = 1; a_hdr = 61'hBAD; a_rx = 1; a_rdy = 1;
    step(); step();
    chk("t5_vld_ignored", 64'(a_vld), 64'd0);
    chk("t5_hdr_ignored", 64'(a_out_hdr), 64'd0);
    #2 idle_inputs(); resetb = 1;
    step();
    chk("t5_vld_release", 64'(a_vld), 64'd0);
    a_push = 1; a_hdr = 61'h50;
    step();
    a_push = 0;
    chk("t5_vld_new", 64'(a_vld), 64'd1);
    chk("t5_hdr_new", 64'(a_out_hdr), 64'h50);
    chk("t5_cnt_new", 64'(a_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cci_tx_c0_buffer.md
CCI_TX_C0_BUFFER -- requirements
Module: cci_tx_c0_buffer

Interface
REQ-001 SHALL have parameter TX_HDR_WIDTH, default 61, meaning TX header width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 4..64).
REQ-003 SHALL have parameter AFULL_THRESH, default 6, meaning occupancy at which almost-full asserts (1..DEPTH-1).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 32, meaning the cap on issued-but-unreturned reads (1..63).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port resetb, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port tx_c0_header, input, TX_HDR_WIDTH, AFU read request header.
REQ-008 SHALL have port tx_c0_rdvalid, input, 1, request push strobe.
REQ-009 SHALL have port tx_c0_almostfull, output, 1, back-pressure to AFU.
REQ-010 SHALL have port out_header, output, TX_HDR_WIDTH, head-of-FIFO header to the emulator.
REQ-011 SHALL have port out_valid, output, 1, head entry issuable.
REQ-012 SHALL have port out_ready, input, 1, emulator accepts the head entry.
REQ-013 SHALL have port rx_c0_rdvalid, input, 1, read response returned; retires one outstanding read.
REQ-014 SHALL have port outstanding_cnt, output, 6, current outstanding read count.
REQ-015 SHALL have port overflow_err, output, 1, sticky error flag.

Function
REQ-016 SHALL write tx_c0_header into the FIFO tail when tx_c0_rdvalid=1 and the FIFO is not full, or is full but a pop occurs in the same cycle.
REQ-017 SHALL drop a push arriving when the FIFO is full with no same-cycle pop, and leave FIFO contents unchanged.
REQ-018 SHALL make a pushed entry visible no earlier than the next cycle (no same-cycle bypass); push into an empty FIFO at cycle N gives out_valid=1 at N+1.
REQ-019 SHALL drive out_valid=1 iff the FIFO is non-empty and outstanding_cnt < MAX_OUTSTANDING.
REQ-020 SHALL drive out_header from the head entry whenever the FIFO is non-empty, and hold it stable while out_valid=1 and out_ready=0.
REQ-021 SHALL pop the head and increment outstanding_cnt on a cycle with out_valid=1 and out_ready=1.
REQ-022 SHALL decrement outstanding_cnt on rx_c0_rdvalid=1, saturating at 0.
REQ-023 SHALL leave outstanding_cnt unchanged when an issue and a return occur in the same cycle.
REQ-024 SHALL drive tx_c0_almostfull combinationally from the registered occupancy: 1 iff occupancy >= AFULL_THRESH.
REQ-025 SHALL keep occupancy unchanged on a simultaneous accepted push and pop.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.

Reset
REQ-027 SHALL, while resetb=0, hold the FIFO empty, pointers 0, outstanding_cnt=0, out_valid=0, tx_c0_almostfull=0, overflow_err=0, and out_header=0.
REQ-028 SHALL discard all buffered and outstanding state on reset assertion mid-operation, and ignore all inputs until resetb returns high.

Configuration
REQ-029 SHALL, with ASE_TX_OVERFLOW_CHECK_EN defined, set overflow_err to 1 on the cycle after a dropped push (REQ-017) or a rx_c0_rdvalid at outstanding_cnt=0, and hold it at 1 until reset.
REQ-030 SHALL, with ASE_TX_OVERFLOW_CHECK_EN undefined, tie overflow_err to 0, while the drop and saturation behaviour stays unchanged.

Structure
REQ-031 SHALL take TX_HDR_WIDTH and the outstanding-counter width constant from the shared ASE CCI package, alongside the existing header bit-range definitions.
REQ-032 SHALL implement storage in a sub-module cci_sync_fifo (parameterised width and depth, push/pop/full/empty/count); counter and issue gating stay in the top module.

Verification
REQ-033 SHALL cover: push 3 headers 0x1,0x2,0x3 with out_ready=1 -> out_valid rises one cycle after the first push; headers emerge in order; outstanding_cnt=3.
REQ-034 SHALL cover: 6 pushes with out_ready=0 -> tx_c0_almostfull=1 the cycle after the 6th push; 8 pushes -> full; 9th push dropped; overflow_err=1 only with the macro defined.
REQ-035 SHALL cover: MAX_OUTSTANDING=2, 4 queued and out_ready=1 -> 2 issued, then out_valid=0; one rx_c0_rdvalid -> out_valid=1 the next cycle and the third entry issues.
REQ-036 SHALL cover: full FIFO with simultaneous push and pop -> push accepted, occupancy stays 8, no error; simultaneous issue and return -> count unchanged.
REQ-037 SHALL cover: 4 entries queued and 2 outstanding, resetb pulsed low asynchronously mid-cycle -> all outputs 0 immediately; after release, first new push appears at the head.
